i2c_byte_engine: RTL and testbench

Byte-level protocol engine of the I2C subordinate. It sits directly downstream of `clockcount` and consumes its `count` bit index together with the `start`/`stop` flags. It assembles address and data bytes from SDA, matches the 7-bit address, and drives ACK and read data onto SDA. It hands received bytes to the register file and requests transmit bytes from it.

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_sda_drive.sv | 22 ++
 rtl/i2c_byte_engine.sv | 158 +++++++++++++++
 tb/tb_i2c_byte_engine.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C subordinate definitions: byte-engine states, bit-slot indices
// and ACK levels, used by the byte engine, clockcount and the register file.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_RD_ACK
    } i2c_state_t;

    localparam logic [3:0] BIT_ACK  = 4'd8;
    localparam logic [3:0] BIT_LAST = 4'd7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // SDA pull-down request implied by the state after a posedge update.
    function automatic logic sda_pull(input i2c_state_t st,
                                      input logic [7:0] txsr);
        logic v;
        v = 1'b0;
        unique case (st)
            S_ADDR_ACK: v = 1'b1;
            S_WR_ACK:   v = 1'b1;
            S_RD:       v = ~txsr[7];
            default:    v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/i2c_sda_drive.sv
// Negedge retiming flop for the SDA pull-down, so SDA only moves while
// SCL is low.
module i2c_sda_drive (
    input  logic i_scl,
    input  logic i_rst,
    input  logic i_oe,
    output logic o_sda_oe
);

    logic r_oe;

    always_ff @(negedge i_scl) begin
        if (!i_rst) begin
            r_oe <= 1'b0;
        end else begin
            r_oe <= i_oe;
        end
    end

    assign o_sda_oe = r_oe;

endmodule

// File: rtl/i2c_byte_engine.sv
// I2C subordinate byte engine: address match, write byte assembly,
// read byte shifting and ACK generation driven by clockcount's bit index.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       scl,
    input  logic       rst,
    input  logic       sda_in,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] count,
    input  logic [7:0] tx_data,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       rw,
    output logic       selected
);

    i2c_state_t r_state;
    logic [7:0] r_sr;
    logic [7:0] r_txsr;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_load;
    logic       r_rw;
    logic       r_sel;

    logic [7:0] w_byte;
    logic       w_oe;

    assign w_byte = {r_sr[6:0], sda_in};
    assign w_oe   = sda_pull(r_state, r_txsr);

    always_ff @(posedge scl) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sr       <= 8'h00;
            r_txsr     <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_rw       <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            if (start) begin
                r_state <= S_ADDR;
                r_sr    <= 8'h00;
                r_sel   <= 1'b0;
            end else if (stop) begin
                r_state <= S_IDLE;
                r_sel   <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                    end
                    S_ADDR: begin
                        if (count < BIT_LAST) begin
                            r_sr <= w_byte;
                        end else if (count == BIT_LAST) begin
                            r_sr <= w_byte;
                            if (w_byte[7:1] == ADDR) begin
                                r_rw    <= w_byte[0];
                                r_sel   <= 1'b1;
                                r_state <= S_ADDR_ACK;
                            end else begin
                                r_sel   <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (count == BIT_ACK) begin
                            if (r_rw) begin
                                r_txsr    <= tx_data;
                                r_tx_load <= 1'b1;
                                r_state   <= S_RD;
                            end else begin
                                r_state   <= S_WR;
                            end
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_WR: begin
                        if (count < BIT_LAST) begin
                            r_sr <= w_byte;
                        end else if (count == BIT_LAST) begin
                            r_sr       <= w_byte;
                            r_rx_data  <= w_byte;
                            r_rx_valid <= 1'b1;
                            r_state    <= S_WR_ACK;
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_WR_ACK: begin
                        if (count == BIT_ACK) begin
                            r_state <= S_WR;
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_RD: begin
                        if (count < BIT_LAST) begin
                            r_txsr <= {r_txsr[6:0], 1'b0};
                        end else if (count == BIT_LAST) begin
                            r_state <= S_RD_ACK;
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_RD_ACK: begin
                        // Master ACK asks for another byte; NACK ends the read.
                        if (count == BIT_ACK && sda_in == ACK) begin
                            r_txsr    <= tx_data;
                            r_tx_load <= 1'b1;
                            r_state   <= S_RD;
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_sel   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    i2c_sda_drive u_sda_drive (
        .i_scl    (scl),
        .i_rst    (rst),
        .i_oe     (w_oe),
        .o_sda_oe (sda_oe)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_load  = r_tx_load;
    assign rw       = r_rw;
    assign selected = r_sel;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine: write, read, address miss,
// repeated START, reset mid-transfer and start/stop collision.
module tb_i2c_byte_engine;
    import i2c_pkg::*;

    logic       scl;
    logic       rst;
    logic       sda_in;
    logic       start;
    logic       stop;
    logic [3:0] count;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw;
    logic       selected;

    int checks;
    int errors;
    int rxv_cnt;
    int txl_cnt;
    logic last_rxv;
    logic last_txl;

    i2c_byte_engine dut (
        .scl      (scl),
        .rst      (rst),
        .sda_in   (sda_in),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .tx_data  (tx_data),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_load  (tx_load),
        .rw       (rw),
        .selected (selected)
    );

    initial scl = 1'b0;
    always #5 scl = ~scl;

    // One SCL period: drive while low, sample posedge flops, then sda_oe.
    task automatic step(input logic st, input logic sp,
                        input logic [3:0] c, input logic d);
        start  = st;
        stop   = sp;
        count  = c;
        sda_in = d;
        @(posedge scl);
        #1;
        last_rxv = rx_valid;
        last_txl = tx_load;
        if (rx_valid) rxv_cnt++;
        if (tx_load) txl_cnt++;
        @(negedge scl);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 4'(i), b[7-i]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        rst = 1'b1;
        checks++;
        if ({sda_oe, rx_valid, tx_load, rw, selected} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {sda_oe, rx_valid, tx_load, rw, selected});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        checks++;
        if (dut.r_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d",
                     dut.r_state, S_IDLE);
        end
    endtask

    task automatic test_write;
        rxv_cnt = 0;
        step(1'b1, 1'b0, 4'd0, 1'b1);
        send_byte(8'h84);
        checks++;
        if ({selected, rw, sda_oe} !== 3'b101) begin
            errors++;
            $display("FAIL wr_addr_ack: sel/rw/oe got %b required 101",
                     {selected, rw, sda_oe});
        end
        step(1'b0, 1'b0, 4'd8, 1'b0);
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_release: got %b required 0", sda_oe);
        end
        send_byte(8'hA5);
        checks++;
        if ({last_rxv, sda_oe} !== 2'b11 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL wr_data: rxv/oe %b rx %h required 11 a5",
                     {last_rxv, sda_oe}, rx_data);
        end
        step(1'b0, 1'b0, 4'd8, 1'b0);
        checks++;
        if ({last_rxv, sda_oe} !== 2'b00) begin
            errors++;
            $display("FAIL wr_after_ack: rxv/oe got %b required 00",
                     {last_rxv, sda_oe});
        end
        step(1'b0, 1'b1, 4'd0, 1'b1);
        checks++;
        if (selected !== 1'b0 || dut.r_state !== S_IDLE) begin
            errors++;
            $display("FAIL wr_stop: sel %b state %0d required 0 %0d",
                     selected, dut.r_state, S_IDLE);
        end
        checks++;
        if (rxv_cnt !== 1 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL wr_rxv_count: got %0d rx %h required 1 a5",
                     rxv_cnt, rx_data);
        end
    endtask

    task automatic read_byte(input logic [7:0] exp, input string tag);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (~sda_oe !== exp[7-k]) begin
                errors++;
                $display("FAIL %s_bit%0d: sda got %b required %b",
                         tag, 7 - k, ~sda_oe, exp[7-k]);
            end
            step(1'b0, 1'b0, 4'(k), 1'b1);
        end
    endtask

    task automatic test_read;
        txl_cnt = 0;
        step(1'b1, 1'b0, 4'd0, 1'b1);
        send_byte(8'h85);
        checks++;
        if ({selected, rw, sda_oe} !== 3'b111) begin
            errors++;
            $display("FAIL rd_addr_ack: sel/rw/oe got %b required 111",
                     {selected, rw, sda_oe});
        end
        tx_data = 8'h3C;
        step(1'b0, 1'b0, 4'd8, 1'b1);
        checks++;
        if (last_txl !== 1'b1) begin
            errors++;
            $display("FAIL rd_load1: got %b required 1", last_txl);
        end
        tx_data = 8'h00;
        read_byte(8'h3C, "rd0");
        checks++;
        if (sda_oe !== 1'b0 || dut.r_state !== S_RD_ACK) begin
            errors++;
            $display("FAIL rd_ack_slot: oe %b state %0d required 0 %0d",
                     sda_oe, dut.r_state, S_RD_ACK);
        end
        tx_data = 8'hF0;
        step(1'b0, 1'b0, 4'd8, ACK);
        tx_data = 8'h00;
        read_byte(8'hF0, "rd1");
        step(1'b0, 1'b0, 4'd8, NACK);
        checks++;
        if (dut.r_state !== S_IDLE || selected !== 1'b0 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_nack: state %0d sel %b oe %b required %0d 0 0",
                     dut.r_state, selected, sda_oe, S_IDLE);
        end
        step(1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (txl_cnt !== 2 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_load_count: got %0d oe %b required 2 0",
                     txl_cnt, sda_oe);
        end
    endtask

    task automatic test_addr_miss;
        logic [7:0] b;
        int oe_seen;
        rxv_cnt = 0;
        oe_seen = 0;
        b = 8'h90;
        step(1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 4'(i), b[7-i]);
            if (sda_oe !== 1'b0) oe_seen++;
        end
        step(1'b0, 1'b0, 4'd8, 1'b1);
        if (sda_oe !== 1'b0) oe_seen++;
        checks++;
        if (oe_seen !== 0) begin
            errors++;
            $display("FAIL miss_oe: driven %0d slots required 0", oe_seen);
        end
        checks++;
        if (selected !== 1'b0 || rxv_cnt !== 0 || dut.r_state !== S_IDLE) begin
            errors++;
            $display("FAIL miss_state: sel %b rxv %0d state %0d required 0 0 %0d",
                     selected, rxv_cnt, dut.r_state, S_IDLE);
        end
    endtask

    task automatic test_repeated_start;
        step(1'b1, 1'b0, 4'd0, 1'b1);
        send_byte(8'h85);
        tx_data = 8'h00;
        step(1'b0, 1'b0, 4'd8, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd1, 1'b1);
        step(1'b0, 1'b0, 4'd2, 1'b1);
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("FAIL rs_driving: got %b required 1", sda_oe);
        end
        step(1'b1, 1'b0, 4'd3, 1'b1);
        checks++;
        if (dut.r_state !== S_ADDR || sda_oe !== 1'b0 || selected !== 1'b0) begin
            errors++;
            $display("FAIL rs_restart: state %0d oe %b sel %b required %0d 0 0",
                     dut.r_state, sda_oe, selected, S_ADDR);
        end
        send_byte(8'h84);
        checks++;
        if ({selected, rw, sda_oe} !== 3'b101) begin
            errors++;
            $display("FAIL rs_new_addr: sel/rw/oe got %b required 101",
                     {selected, rw, sda_oe});
        end
        step(1'b0, 1'b0, 4'd8, 1'b0);
        step(1'b0, 1'b1, 4'd0, 1'b1);
    endtask

    task automatic test_reset_mid;
        step(1'b1, 1'b0, 4'd0, 1'b1);
        send_byte(8'h84);
        step(1'b0, 1'b0, 4'd8, 1'b0);
        send_byte(8'h5A);
        checks++;
        if (sda_oe !== 1'b1 || rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL rm_pre: oe %b rx %h required 1 5a", sda_oe, rx_data);
        end
        rxv_cnt = 0;
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd8, 1'b0);
        rst = 1'b1;
        checks++;
        if ({sda_oe, rx_valid, tx_load, rw, selected} !== 5'b0 ||
            rx_data !== 8'h00 || rxv_cnt !== 0) begin
            errors++;
            $display("FAIL rm_outputs: flags %b rx %h rxv %0d required 00000 00 0",
                     {sda_oe, rx_valid, tx_load, rw, selected}, rx_data, rxv_cnt);
        end
        checks++;
        if (dut.r_state !== S_IDLE) begin
            errors++;
            $display("FAIL rm_state: got %0d required %0d", dut.r_state, S_IDLE);
        end
    endtask

    task automatic test_start_stop;
        step(1'b1, 1'b0, 4'd0, 1'b1);
        send_byte(8'h85);
        tx_data = 8'hFF;
        step(1'b0, 1'b0, 4'd8, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd1, 1'b1);
        checks++;
        if (dut.r_state !== S_ADDR || selected !== 1'b0) begin
            errors++;
            $display("FAIL ss_collision: state %0d sel %b required %0d 0",
                     dut.r_state, selected, S_ADDR);
        end
        step(1'b0, 1'b1, 4'd0, 1'b1);
        checks++;
        if (dut.r_state !== S_IDLE) begin
            errors++;
            $display("FAIL ss_stop: state %0d required %0d", dut.r_state, S_IDLE);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rxv_cnt = 0;
        txl_cnt = 0;
        rst     = 1'b0;
        sda_in  = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        count   = 4'd0;
        tx_data = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_addr_miss;
        test_repeated_start;
        test_reset_mid;
        test_start_stop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
